// File: rtl/bg_pixel_fetch.sv
// Background pixel fetch: maps the VGA raster (plus a per-frame vertical scroll) to a ROM address and
// realigns the returned palette index with delayed sync. Define BG_HALF_RES_EN for the 320x240 pixel-doubled image.
module bg_pixel_fetch (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        scroll_en,
    input  logic [3:0]  scroll_step,
    output logic [18:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  index,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic [7:0]  frame_cnt
);

`ifdef BG_HALF_RES_EN
    localparam int unsigned IMG_H   = 240;
    localparam int unsigned SHIFT_A = 8;   // 320 = 256 + 64
    localparam int unsigned SHIFT_B = 6;
`else
    localparam int unsigned IMG_H   = 480;
    localparam int unsigned SHIFT_A = 9;   // 640 = 512 + 128
    localparam int unsigned SHIFT_B = 7;
`endif
    localparam int unsigned SCR_W   = 640;
    localparam int unsigned SCR_H   = 480;
    localparam logic [3:0]  BLACK   = 4'h8;

    logic [9:0]  x_img;
    logic [9:0]  y_img;
    logic [10:0] row_sum;
    logic [8:0]  row;
    logic [18:0] addr_c;
    logic [9:0]  scroll_sum;
    logic [8:0]  scroll_next;
    logic [8:0]  scroll_y;
    logic        vs_smp;
    logic        frame_edge;
    logic [1:0]  de_d;
    logic [1:0]  hs_d;
    logic [1:0]  vs_d;

    // Raster to image coordinates, then scrolled row and shift-add address.
    always_comb begin
`ifdef BG_HALF_RES_EN
        x_img = drawX >> 1;
        y_img = drawY >> 1;
`else
        x_img = drawX;
        y_img = drawY;
`endif
        row_sum = 11'(y_img) + 11'(scroll_y);
        if (row_sum >= 11'(IMG_H)) begin
            row_sum = row_sum - 11'(IMG_H);
        end
        row    = 9'(row_sum);
        addr_c = (19'(row) << SHIFT_A) + (19'(row) << SHIFT_B) + 19'(x_img);
        if ((drawX >= 10'(SCR_W)) || (drawY >= 10'(SCR_H))) begin
            addr_c = '0;
        end
    end

    // Scroll offset candidate for the next frame; both operands stay below IMG_H + 16.
    always_comb begin
        scroll_sum = 10'(scroll_y) + 10'(scroll_step);
        if (scroll_sum >= 10'(IMG_H)) begin
            scroll_sum = scroll_sum - 10'(IMG_H);
        end
        scroll_next = 9'(scroll_sum);
    end

    assign frame_edge = vs_smp & ~vs_in;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr  <= '0;
            index     <= BLACK;
            de_d      <= 2'b00;
            hs_d      <= 2'b11;
            vs_d      <= 2'b11;
            de_out    <= 1'b0;
            hs_out    <= 1'b1;
            vs_out    <= 1'b1;
            vs_smp    <= 1'b1;
            frame_cnt <= '0;
            scroll_y  <= '0;
        end else begin
            rom_addr <= addr_c;
            de_d     <= {de_d[0], de_in};
            hs_d     <= {hs_d[0], hs_in};
            vs_d     <= {vs_d[0], vs_in};
            de_out   <= de_d[1];
            hs_out   <= hs_d[1];
            vs_out   <= vs_d[1];
            // rom_data here answers the address issued two edges ago, matching de_d[1]
            index    <= de_d[1] ? rom_data : BLACK;
            vs_smp   <= vs_in;
            if (frame_edge) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (scroll_en) begin
                    scroll_y <= scroll_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Directed bench for bg_pixel_fetch: reference address/scroll model, ROM model and a queue of
// expected stage-3 outputs compared as the pipeline drains.
module tb_bg_pixel_fetch;

`ifdef BG_HALF_RES_EN
    localparam int H = 240;
    localparam int W = 320;
`else
    localparam int H = 480;
    localparam int W = 640;
`endif

    typedef struct packed {
        logic [3:0] idx;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic        de_in = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        scroll_en = 1'b0;
    logic [3:0]  scroll_step = '0;
    logic [18:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  index;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;
    logic [7:0]  frame_cnt;

    int   checks = 0;
    int   failures = 0;
    int   m_scroll = 0;
    int   m_frame = 0;
    logic m_vs_prev = 1'b1;
    exp_t q[$];

    bg_pixel_fetch dut (
        .vga_clk(vga_clk), .reset(reset), .drawX(drawX), .drawY(drawY),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .scroll_en(scroll_en), .scroll_step(scroll_step),
        .rom_addr(rom_addr), .rom_data(rom_data), .index(index),
        .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .frame_cnt(frame_cnt)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_f(input logic [18:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
    endfunction

    // Synchronous ROM: data for an address is valid one edge later.
    always @(posedge vga_clk) rom_data <= rom_f(rom_addr);

    function automatic int model_addr(input int x, input int y, input int s);
        int xi, yi, r;
        if (x >= 640 || y >= 480) return 0;
`ifdef BG_HALF_RES_EN
        xi = x / 2;
        yi = y / 2;
`else
        xi = x;
        yi = y;
`endif
        r = (yi + s) % H;
        return r * W + xi;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_t r;
        m_scroll  = 0;
        m_frame   = 0;
        m_vs_prev = 1'b1;
        q.delete();
        r = '{idx: 4'h8, de: 1'b0, hs: 1'b1, vs: 1'b1};
        q.push_back(r);
        q.push_back(r);
    endtask

    task automatic cyc(input int x, input int y, input logic de, input logic hs, input logic vs,
                       input logic sen, input int step);
        int   ea;
        exp_t e;
        exp_t got;
        drawX = 10'(x); drawY = 10'(y);
        de_in = de; hs_in = hs; vs_in = vs;
        scroll_en = sen; scroll_step = 4'(step);
        @(posedge vga_clk);
        #1;
        ea = model_addr(x, y, m_scroll);
        if (m_vs_prev && !vs) begin
            m_frame = (m_frame + 1) % 256;
            if (sen) m_scroll = (m_scroll + step) % H;
        end
        m_vs_prev = vs;
        e = '{idx: (de ? rom_f(19'(ea)) : 4'h8), de: de, hs: hs, vs: vs};
        q.push_back(e);
        got = q.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        chk("index", 32'(index), 32'(got.idx));
        chk("de_out", 32'(de_out), 32'(got.de));
        chk("hs_out", 32'(hs_out), 32'(got.hs));
        chk("vs_out", 32'(vs_out), 32'(got.vs));
    endtask

    task automatic frame(input logic sen, input int step);
        cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 15);
        cyc(0, 0, 1'b0, 1'b1, 1'b0, sen, step);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_index"}, 32'(index), 32'h8);
        chk({tag, "_de"}, 32'(de_out), 32'h0);
        chk({tag, "_hs"}, 32'(hs_out), 32'h1);
        chk({tag, "_vs"}, 32'(vs_out), 32'h1);
        chk({tag, "_addr"}, 32'(rom_addr), 32'h0);
        chk({tag, "_frame"}, 32'(frame_cnt), 32'h0);
    endtask

    initial begin
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;
        model_reset();

        // Basic fetch, blanking, hsync pulse, out-of-range and last-pixel addresses
        cyc(5, 3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(100, 200, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cyc(10, 10, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        cyc(11, 10, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(640, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(0, 480, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (3) cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        // Scroll by 5 twice, then a long vsync low must count once
        frame(1'b1, 5);
        frame(1'b1, 5);
        repeat (20) cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        cyc(0, 475, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        chk("scroll10_frame", 32'(frame_cnt), 32'd2);

        // Walk scroll to 470, then wrap with step 15
        repeat (46) frame(1'b1, 10);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        frame(1'b1, 15);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(7, 475, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        // Frames with scroll disabled until the counter wraps
        repeat (207) frame(1'b0, 9);
        cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("frame_wrap", 32'(frame_cnt), 32'd0);

        // Mid-frame asynchronous reset
        frame(1'b1, 7);
        cyc(20, 30, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(21, 30, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid");
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc(5, 3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(6, 3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (3) cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
